// File: rtl/basilisk_pkg.sv
// Shared FPU writeback types: the result payload that travels from each FPU
// pipe to the FP register-file write port, and the default number of such pipes.
package basilisk_pkg;

  localparam int BASILISK_WRITEBACK_PORTS = 4;
  localparam int BASILISK_REG_ADDR_W      = 5;
  localparam int BASILISK_OFFSET_ADDR_W   = 5;
  localparam int BASILISK_RESULT_W        = 32;

  typedef struct packed {
    logic [BASILISK_REG_ADDR_W-1:0]    dest_reg_addr;
    logic [BASILISK_OFFSET_ADDR_W-1:0] dest_offset_addr;
    logic [BASILISK_RESULT_W-1:0]      result;
  } basilisk_writeback_result_t;

endpackage

// File: rtl/basilisk_rr_arbiter.sv
// Combinational rotating-priority selector: grants the first set request
// bit found searching upward from ptr, wrapping modulo NUM_INPUTS.
module basilisk_rr_arbiter #(
  parameter int NUM_INPUTS = 4,
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic [NUM_INPUTS-1:0] request,
  input  logic [IDX_W-1:0]      ptr,
  output logic [NUM_INPUTS-1:0] grant,
  output logic [IDX_W-1:0]      grant_index
);

  logic             found_s;
  logic [IDX_W-1:0] idx_s;

  // Walk candidates in priority order; the first requester seen wins.
  always_comb begin
    grant       = '0;
    grant_index = '0;
    found_s     = 1'b0;
    idx_s       = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      idx_s = IDX_W'((int'(ptr) + k) % NUM_INPUTS);
      if (!found_s && request[idx_s]) begin
        found_s            = 1'b1;
        grant[idx_s]       = 1'b1;
        grant_index        = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/basilisk_writeback_arbiter.sv
// Arbitrates the FPU result streams onto the single FP register-file write
// port through a one-deep registered output stage with round-robin fairness.
module basilisk_writeback_arbiter
  import basilisk_pkg::*;
#(
  parameter int NUM_INPUTS = BASILISK_WRITEBACK_PORTS,
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_INPUTS-1:0]      in_valid,
  output logic [NUM_INPUTS-1:0]      in_ready,
  input  basilisk_writeback_result_t in_result [NUM_INPUTS],
  output logic                       out_valid,
  input  logic                       out_ready,
  output basilisk_writeback_result_t out_result,
  output logic [IDX_W-1:0]           out_source
);

  logic [IDX_W-1:0]      ptr_r;
  logic [NUM_INPUTS-1:0] grant_s;
  logic [IDX_W-1:0]      grant_index_s;
  logic                  load_en_s;
  logic                  any_grant_s;

  basilisk_rr_arbiter #(
    .NUM_INPUTS (NUM_INPUTS)
  ) u_rr_arbiter (
    .request     (in_valid),
    .ptr         (ptr_r),
    .grant       (grant_s),
    .grant_index (grant_index_s)
  );

  // The output register can take a new beat when empty or being drained now.
  always_comb begin
    load_en_s   = !out_valid || out_ready;
    any_grant_s = |grant_s;
  end

  // Only the winner sees ready, and nobody does while reset or stalled.
  always_comb begin
    if (rst) begin
      in_ready = '0;
    end else if (load_en_s) begin
      in_ready = grant_s;
    end else begin
      in_ready = '0;
    end
  end

  // Output stage and priority pointer; reset drops any held beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_source <= '0;
      ptr_r      <= '0;
    end else if (load_en_s) begin
      if (any_grant_s) begin
        out_valid  <= 1'b1;
        out_result <= in_result[grant_index_s];
        out_source <= grant_index_s;
        if (grant_index_s == IDX_W'(NUM_INPUTS - 1)) begin
          ptr_r <= '0;
        end else begin
          ptr_r <= grant_index_s + IDX_W'(1);
        end
      end else begin
        out_valid <= 1'b0;
      end
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule
